decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32E/RV32I instruction decode stage.
// Takes raw instruction words from fetch and presents registered decoded
// fields (class, register indices, funct bits, immediate, illegal flag) to
// execute. Optional macro DECODE_SKID_EN adds a second buffer entry so that
// in_ready is driven from a register and the stage sustains one instruction
// per cycle without a combinational path from out_ready to in_ready.
//
// Handshake: a beat transfers on a rising clock edge where valid && ready are
// both 1. The producer holds valid and data stable until the transfer. Flush
// overrides both handshakes and discards every held beat, plus any input
// transfer offered in the same cycle.
module decode_stage #(
  parameter int NUM_REGS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_class,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic        out_funct7_5,
  output logic [31:0] out_imm,
  output logic        out_illegal
);

  // Only the two base integer register files are meaningful.
  if (NUM_REGS != 16 && NUM_REGS != 32) begin : g_bad_num_regs
    $error("decode_stage: NUM_REGS must be 16 or 32");
  end

  localparam logic [3:0] CLS_ILLEGAL = 4'd0;
  localparam logic [3:0] CLS_LUI     = 4'd1;
  localparam logic [3:0] CLS_AUIPC   = 4'd2;
  localparam logic [3:0] CLS_JAL     = 4'd3;
  localparam logic [3:0] CLS_JALR    = 4'd4;
  localparam logic [3:0] CLS_BRANCH  = 4'd5;
  localparam logic [3:0] CLS_LOAD    = 4'd6;
  localparam logic [3:0] CLS_STORE   = 4'd7;
  localparam logic [3:0] CLS_OP_IMM  = 4'd8;
  localparam logic [3:0] CLS_OP      = 4'd9;
  localparam logic [3:0] CLS_FENCE   = 4'd10;
  localparam logic [3:0] CLS_SYSTEM  = 4'd11;

  // With 16 registers any index with bit 4 set is out of range.
  localparam logic LIMIT16 = (NUM_REGS == 16);

  // Decoded bundle: {class, rd, rs1, rs2, funct3, funct7_5, imm, illegal}.
  localparam int DW = 56;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic        rd_hi, rs1_hi, rs2_hi;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc    = in_data[6:0];
  assign f3     = in_data[14:12];
  assign f7     = in_data[31:25];
  assign rd     = in_data[11:7];
  assign rs1    = in_data[19:15];
  assign rs2    = in_data[24:20];
  assign rd_hi  = LIMIT16 & rd[4];
  assign rs1_hi = LIMIT16 & rs1[4];
  assign rs2_hi = LIMIT16 & rs2[4];

  assign imm_i = {{20{in_data[31]}}, in_data[31:20]};
  assign imm_s = {{20{in_data[31]}}, in_data[31:25], in_data[11:7]};
  assign imm_b = {{19{in_data[31]}}, in_data[31], in_data[7], in_data[30:25],
                  in_data[11:8], 1'b0};
  assign imm_u = {in_data[31:12], 12'b0};
  assign imm_j = {{11{in_data[31]}}, in_data[31], in_data[19:12], in_data[20],
                  in_data[30:21], 1'b0};

  logic [3:0]  cls, dec_class;
  logic [31:0] imm, dec_imm;
  logic        bad, dec_illegal;

  // Classify the word, pick its immediate format and collect illegal conditions.
  always_comb begin
    cls         = CLS_ILLEGAL;
    imm         = '0;
    bad         = 1'b0;
    dec_class   = CLS_ILLEGAL;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (opc)
      7'b0110111: begin cls = CLS_LUI;    imm = imm_u; bad = rd_hi; end
      7'b0010111: begin cls = CLS_AUIPC;  imm = imm_u; bad = rd_hi; end
      7'b1101111: begin cls = CLS_JAL;    imm = imm_j; bad = rd_hi; end
      7'b1100111: begin
        cls = CLS_JALR; imm = imm_i;
        bad = (f3 != 3'b000) | rd_hi | rs1_hi;
      end
      7'b1100011: begin
        cls = CLS_BRANCH; imm = imm_b;
        bad = (f3 == 3'b010) | (f3 == 3'b011) | rs1_hi | rs2_hi;
      end
      7'b0000011: begin
        cls = CLS_LOAD; imm = imm_i;
        bad = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111) | rd_hi | rs1_hi;
      end
      7'b0100011: begin
        cls = CLS_STORE; imm = imm_s;
        bad = (f3 >= 3'b011) | rs1_hi | rs2_hi;
      end
      7'b0010011: begin
        cls = CLS_OP_IMM; imm = imm_i;
        bad = ((f3 == 3'b001) & (f7 != 7'h00))
            | ((f3 == 3'b101) & (f7 != 7'h00) & (f7 != 7'h20))
            | rd_hi | rs1_hi;
      end
      7'b0110011: begin
        cls = CLS_OP;
        bad = ((f7 != 7'h00) & (f7 != 7'h20))
            | ((f7 == 7'h20) & (f3 != 3'b000) & (f3 != 3'b101))
            | rd_hi | rs1_hi | rs2_hi;
      end
      7'b0001111: begin
        cls = CLS_FENCE;
        bad = (f3 != 3'b000) | rd_hi | rs1_hi;
      end
      7'b1110011: begin
        cls = CLS_SYSTEM;
        bad = (in_data != 32'h0000_0073) & (in_data != 32'h0010_0073);
      end
      default: bad = 1'b1;
    endcase
    if (in_data[1:0] != 2'b11) bad = 1'b1;
    dec_illegal = bad;
    dec_class   = bad ? CLS_ILLEGAL : cls;
    dec_imm     = bad ? 32'h0 : imm;
  end

  logic [DW-1:0] dec_bus, out_q;
  logic          out_valid_q;

  assign dec_bus = {dec_class, rd, rs1, rs2, f3, in_data[30], dec_imm, dec_illegal};
  assign {out_class, out_rd, out_rs1, out_rs2, out_funct3, out_funct7_5,
          out_imm, out_illegal} = out_q;
  assign out_valid = out_valid_q;

`ifdef DECODE_SKID_EN
  logic [DW-1:0] skid_q;
  logic          skid_full;

  // Ready depends only on skid occupancy, so it is purely registered.
  assign in_ready = ~skid_full;

  // Output register refills from the skid entry first to keep order;
  // a beat arriving while the output is stalled parks in the skid entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_full   <= 1'b0;
      skid_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_full   <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_full) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
        skid_full   <= 1'b0;
      end else if (in_valid) begin
        out_q       <= dec_bus;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid && !skid_full) begin
      skid_q    <= dec_bus;
      skid_full <= 1'b1;
    end
  end
`else
  // Accept whenever the output register is empty or draining this cycle.
  assign in_ready = ~out_valid_q | out_ready;

  // Single output register: load on input transfer, empty when drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_q       <= dec_bus;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a NUM_REGS=16 and a NUM_REGS=32 instance share the
// same stimulus; each has its own expected queue filled from a reference
// decoder at input transfer and drained at output transfer.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        in_ready, out_valid, out_funct7_5, out_illegal;
  logic [3:0]  out_class;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [31:0] out_imm;

  logic        in_ready_b, out_valid_b, out_funct7_5_b, out_illegal_b;
  logic [3:0]  out_class_b;
  logic [4:0]  out_rd_b, out_rs1_b, out_rs2_b;
  logic [2:0]  out_funct3_b;
  logic [31:0] out_imm_b;

  logic [55:0] exp_q[$];
  logic [55:0] exp_b_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  decode_stage #(.NUM_REGS(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7_5(out_funct7_5),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  decode_stage #(.NUM_REGS(32)) dut32 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_class(out_class_b), .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
    .out_funct3(out_funct3_b), .out_funct7_5(out_funct7_5_b),
    .out_imm(out_imm_b), .out_illegal(out_illegal_b)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder written straight from the instruction-set tables.
  function automatic logic [55:0] model(input logic [31:0] w, input int nregs);
    logic [3:0]  c;
    logic [31:0] im;
    logic        ill;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          rdi, rs1i, rs2i;
    f3 = w[14:12]; f7 = w[31:25];
    rdi = int'(w[11:7]); rs1i = int'(w[19:15]); rs2i = int'(w[24:20]);
    c = 4'd0; im = 32'h0; ill = 1'b0;
    case (w[6:0])
      7'h37: begin c = 4'd1; im = w & 32'hFFFF_F000; ill = rdi >= nregs; end
      7'h17: begin c = 4'd2; im = w & 32'hFFFF_F000; ill = rdi >= nregs; end
      7'h6F: begin
        c = 4'd3;
        im = {w[31] ? 11'h7FF : 11'h0, w[31], w[19:12], w[20], w[30:21], 1'b0};
        ill = rdi >= nregs;
      end
      7'h67: begin
        c = 4'd4; im = 32'($signed(w[31:20]));
        ill = f3 != 0 || rdi >= nregs || rs1i >= nregs;
      end
      7'h63: begin
        c = 4'd5; im = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        ill = f3 == 2 || f3 == 3 || rs1i >= nregs || rs2i >= nregs;
      end
      7'h03: begin
        c = 4'd6; im = 32'($signed(w[31:20]));
        ill = f3 == 3 || f3 == 6 || f3 == 7 || rdi >= nregs || rs1i >= nregs;
      end
      7'h23: begin
        c = 4'd7; im = 32'($signed({w[31:25], w[11:7]}));
        ill = f3 >= 3 || rs1i >= nregs || rs2i >= nregs;
      end
      7'h13: begin
        c = 4'd8; im = 32'($signed(w[31:20]));
        ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20))
              || rdi >= nregs || rs1i >= nregs;
      end
      7'h33: begin
        c = 4'd9;
        ill = !(f7 == 0 || f7 == 7'h20) || (f7 == 7'h20 && !(f3 == 0 || f3 == 5))
              || rdi >= nregs || rs1i >= nregs || rs2i >= nregs;
      end
      7'h0F: begin c = 4'd10; ill = f3 != 0 || rdi >= nregs || rs1i >= nregs; end
      7'h73: begin c = 4'd11; ill = !(w == 32'h73 || w == 32'h0010_0073); end
      default: ill = 1'b1;
    endcase
    if (ill) begin c = 4'd0; im = 32'h0; end
    return {c, w[11:7], w[19:15], w[24:20], w[14:12], w[30], im, ill};
  endfunction

  function automatic logic [55:0] obs_a();
    return {out_class, out_rd, out_rs1, out_rs2, out_funct3, out_funct7_5, out_imm, out_illegal};
  endfunction

  function automatic logic [55:0] obs_b();
    return {out_class_b, out_rd_b, out_rs1_b, out_rs2_b, out_funct3_b, out_funct7_5_b,
            out_imm_b, out_illegal_b};
  endfunction

  task automatic compare_beat(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    check_eq({tag, "_class"}, 64'(obs[55:52]), 64'(exp[55:52]));
    check_eq({tag, "_imm"}, 64'(obs[32:1]), 64'(exp[32:1]));
    check_eq({tag, "_fields"}, 64'({obs[51:33], obs[0]}), 64'({exp[51:33], exp[0]}));
  endtask

  // One clock: settle inputs, score transfers due at the coming edge, advance.
  task automatic cycle();
    #1;
    if (flush) begin
      exp_q.delete();
      exp_b_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("q16_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) compare_beat("beat16", obs_a(), exp_q.pop_front());
      end
      if (out_valid_b && out_ready) begin
        check_eq("q32_nonempty", 64'(exp_b_q.size() != 0), 64'd1);
        if (exp_b_q.size() != 0) compare_beat("beat32", obs_b(), exp_b_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, 16));
      if (in_valid && in_ready_b) exp_b_q.push_back(model(in_data, 32));
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [6:0]  opcs [11];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
    if ($urandom_range(0, 1) == 1) begin w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0; end
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1)
      w = ($urandom_range(0, 1) == 1) ? 32'h0000_0073 : 32'h0010_0073;
    return w;
  endfunction

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;

    // Reset state
    @(negedge clock);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_imm", 64'(out_imm), 64'd0);
    check_eq("rst_out_class", 64'(out_class), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // addi x1,x0,5: one-cycle latency
    in_valid = 1'b1; in_data = 32'h0050_0093; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("lat_valid", 64'(out_valid), 64'd1);
    check_eq("addi_class", 64'(out_class), 64'd8);
    check_eq("addi_imm", 64'(out_imm), 64'h5);
    cycle();

    // Branch then LUI back to back, no bubble
    in_valid = 1'b1; in_data = 32'hFE00_0EE3;
    cycle();
    check_eq("b2b_valid1", 64'(out_valid), 64'd1);
    check_eq("branch_imm", 64'(out_imm), 64'hFFFF_FFFC);
    in_data = 32'h1234_52B7;
    cycle();
    in_valid = 1'b0;
    check_eq("b2b_valid2", 64'(out_valid), 64'd1);
    check_eq("lui_rd", 64'(out_rd), 64'd5);
    check_eq("lui_imm", 64'(out_imm), 64'h1234_5000);
    cycle();

    // add x16,x0,x0: illegal with 16 registers, legal with 32
    in_valid = 1'b1; in_data = 32'h0000_0833;
    cycle();
    in_valid = 1'b0;
    check_eq("x16_ill16", 64'(out_illegal), 64'd1);
    check_eq("x16_cls16", 64'(out_class), 64'd0);
    check_eq("x16_cls32", 64'(out_class_b), 64'd9);
    check_eq("x16_rd32", 64'(out_rd_b), 64'd16);
    cycle();

    // Back-pressure: A then B with out_ready low
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0050_0093;
    cycle();
`ifdef DECODE_SKID_EN
    check_eq("skid_rdy_after_a", 64'(in_ready), 64'd1);
    in_data = 32'h1234_52B7;
    cycle();
    in_valid = 1'b0;
    check_eq("skid_rdy_after_b", 64'(in_ready), 64'd0);
    cycle();
    check_eq("skid_hold_imm", 64'(out_imm), 64'h5);
    out_ready = 1'b1;
    cycle();
    check_eq("skid_rdy_after_drain", 64'(in_ready), 64'd1);
    check_eq("skid_b_valid", 64'(out_valid), 64'd1);
    check_eq("skid_b_imm", 64'(out_imm), 64'h1234_5000);
    cycle();
`else
    in_valid = 1'b0;
    check_eq("stall_rdy", 64'(in_ready), 64'd0);
    cycle();
    check_eq("stall_hold_imm", 64'(out_imm), 64'h5);
    out_ready = 1'b1;
    cycle();
`endif
    check_eq("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush with buffers full and an input offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0050_0093;
    cycle();
    in_data = 32'h1234_52B7;
    cycle();
    flush = 1'b1; in_data = 32'hFE00_0EE3;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // Random traffic with random back-pressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_word();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    check_eq("rand_drain16", 64'(exp_q.size()), 64'd0);
    check_eq("rand_drain32", 64'(exp_b_q.size()), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0050_0093;
    cycle();
    in_valid = 1'b0;
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_rdy", 64'(in_ready), 64'd1);
    check_eq("arst_imm", 64'(out_imm), 64'd0);
    exp_q.delete();
    exp_b_q.delete();
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (2) cycle();
    check_eq("post_rst_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
